// File: rtl/sdram_test_pkg.sv
// Shared types and the test pattern used by the SDRAM writer and read checker.
package sdram_test_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRecv,
        StFin
    } state_e;

    localparam int unsigned BurstMaxDefault = 64;

    // Word n of the test pattern: inverted index in the upper half, index in the lower half.
    function automatic logic [127:0] expected_word(input logic [63:0] n);
        return {~n, n};
    endfunction

endpackage

// File: rtl/sdram_read_checker_if.sv
// Avalon-MM read master bundle between the checker and the SDRAM controller.
interface sdram_read_checker_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
);
    logic [ADDR_W-1:0] avm_address_o;
    logic [7:0]        avm_burstcount_o;
    logic              avm_read_o;
    logic              avm_waitrequest_i;
    logic [DATA_W-1:0] avm_readdata_i;
    logic              avm_readdatavalid_i;

    modport master (
        output avm_address_o,
        output avm_burstcount_o,
        output avm_read_o,
        input  avm_waitrequest_i,
        input  avm_readdata_i,
        input  avm_readdatavalid_i
    );

    modport slave (
        input  avm_address_o,
        input  avm_burstcount_o,
        input  avm_read_o,
        output avm_waitrequest_i,
        output avm_readdata_i,
        output avm_readdatavalid_i
    );
endinterface

// File: rtl/rd_pattern_cmp.sv
// Compares one returned read beat against the expected pattern word for its index.
module rd_pattern_cmp
    import sdram_test_pkg::*;
(
    input  logic [31:0]  idx_i,
    input  logic [127:0] data_i,
    output logic         mismatch_o
);

    // Purely combinational; the checker registers the outcome.
    always_comb begin
        mismatch_o = (data_i != expected_word({32'd0, idx_i}));
    end

endmodule

// File: rtl/sdram_read_checker.sv
// Reads back a region of SDRAM in bursts and counts words that differ from the test pattern.
module sdram_read_checker
    import sdram_test_pkg::*;
#(
    parameter int unsigned ADDR_W    = 28,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned BURST_MAX = BurstMaxDefault
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        run_stb_i,
    input  logic [31:0]                 base_addr_i,
    input  logic [31:0]                 size_i,
    sdram_read_checker_if.master        avm,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [31:0]                 err_cnt_o,
    output logic [31:0]                 first_err_idx_o,
    output logic [31:0]                 cycle_cnt_o
);

    localparam logic [31:0] BurstMaxW = 32'(BURST_MAX);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         remaining_q, remaining_d;
    logic [31:0]         idx_q, idx_d;
    logic [7:0]          beats_q, beats_d;
    logic [31:0]         err_cnt_q, err_cnt_d;
    logic [31:0]         first_err_q, first_err_d;
    logic [31:0]         cycle_cnt_q, cycle_cnt_d;

    logic [7:0]          burst_len;
    logic                read;
    logic [7:0]          burstcount;
    logic                mismatch;
    logic [DATA_W-1:0]   rdata;
    logic                unused_base;

    // Only the low ADDR_W bits of the base address are meaningful.
    assign unused_base = ^(base_addr_i >> ADDR_W);
    assign rdata       = avm.avm_readdata_i;

    rd_pattern_cmp u_cmp (
        .idx_i      (idx_q),
        .data_i     (rdata[127:0]),
        .mismatch_o (mismatch)
    );

    // Burst length for the next request: whatever is left, capped at BURST_MAX.
    always_comb begin
        burst_len = (remaining_q > BurstMaxW) ? BurstMaxW[7:0] : remaining_q[7:0];
    end

    // Next-state logic and Avalon request outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        beats_d     = beats_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        cycle_cnt_d = (state_q != StIdle) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
        read        = 1'b0;
        burstcount  = 8'd0;

        unique case (state_q)
            StIdle: begin
                if (run_stb_i) begin
                    addr_d      = base_addr_i[ADDR_W-1:0];
                    remaining_d = size_i;
                    idx_d       = 32'd0;
                    err_cnt_d   = 32'd0;
                    first_err_d = '1;
                    cycle_cnt_d = 32'd0;
                    state_d     = (size_i == 32'd0) ? StFin : StReq;
                end
            end
            StReq: begin
                // Request fields come straight from registers, so they hold during waitrequest.
                read       = 1'b1;
                burstcount = burst_len;
                if (!avm.avm_waitrequest_i) begin
                    addr_d      = addr_q + ADDR_W'(burst_len);
                    remaining_d = remaining_q - 32'(burst_len);
                    beats_d     = burst_len;
                    state_d     = StRecv;
                end
            end
            StRecv: begin
                if (avm.avm_readdatavalid_i) begin
                    idx_d = idx_q + 32'd1;
                    if (mismatch) begin
                        err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 32'd1;
                        if (first_err_q == '1) begin
                            first_err_d = idx_q;
                        end
                    end
                    beats_d = beats_q - 8'd1;
                    if (beats_q == 8'd1) begin
                        state_d = (remaining_q != 32'd0) ? StReq : StFin;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= 32'd0;
            idx_q       <= 32'd0;
            beats_q     <= 8'd0;
            err_cnt_q   <= 32'd0;
            first_err_q <= '1;
            cycle_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            beats_q     <= beats_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign avm.avm_address_o    = addr_q;
    assign avm.avm_burstcount_o = burstcount;
    assign avm.avm_read_o       = read;
    assign busy_o               = (state_q != StIdle);
    assign done_o               = (state_q == StFin);
    assign err_cnt_o            = err_cnt_q;
    assign first_err_idx_o      = first_err_q;
    assign cycle_cnt_o          = cycle_cnt_q;

endmodule

// File: tb/tb_sdram_read_checker.sv
// Randomized bench for sdram_read_checker: Avalon slave model plus transaction-level reference.
module tb_sdram_read_checker;

    logic        clk;
    logic        rst;
    logic        run_stb;
    logic [31:0] base_addr;
    logic [31:0] size;
    logic        busy;
    logic        done;
    logic [31:0] err_cnt;
    logic [31:0] first_err;
    logic [31:0] cycle_cnt;

    sdram_read_checker_if avm_if ();

    sdram_read_checker dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .run_stb_i       (run_stb),
        .base_addr_i     (base_addr),
        .size_i          (size),
        .avm             (avm_if),
        .busy_o          (busy),
        .done_o          (done),
        .err_cnt_o       (err_cnt),
        .first_err_idx_o (first_err),
        .cycle_cnt_o     (cycle_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- Avalon slave model ----------------
    int  s_pend = 0;
    int  s_n = 0;
    int  hold_left = 0;
    bit  corrupt_map [512];
    logic cur_corrupt = 1'b0;

    initial begin
        logic        sm_read;
        logic        sm_wait;
        logic [7:0]  sm_bc;
        logic [63:0] n64;
        logic [127:0] word;
        avm_if.avm_waitrequest_i   = 1'b0;
        avm_if.avm_readdatavalid_i = 1'b0;
        avm_if.avm_readdata_i      = '0;
        forever begin
            @(negedge clk);
            sm_read = avm_if.avm_read_o;
            sm_wait = avm_if.avm_waitrequest_i;
            sm_bc   = avm_if.avm_burstcount_o;
            @(posedge clk);
            #1;
            if (sm_read === 1'b1 && sm_wait === 1'b0) s_pend += int'(sm_bc);
            if (sm_read === 1'b1 && sm_wait === 1'b1 && hold_left > 0) hold_left--;
            avm_if.avm_waitrequest_i = (hold_left > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            if (s_pend > 0 && $urandom_range(0, 3) != 0) begin
                n64  = 64'(s_n);
                word = {~n64, n64};
                cur_corrupt = (s_n < 512) ? corrupt_map[s_n] : 1'b0;
                if (cur_corrupt) word[$urandom_range(0, 127)] ^= 1'b1;
                avm_if.avm_readdata_i      = word;
                avm_if.avm_readdatavalid_i = 1'b1;
                s_n++;
                s_pend--;
            end else begin
                cur_corrupt = 1'b0;
                avm_if.avm_readdata_i      = {$urandom, $urandom, $urandom, $urandom};
                avm_if.avm_readdatavalid_i = 1'b0;
            end
        end
    end

    // ---------------- Reference model and per-cycle compare ----------------
    typedef struct {
        logic [27:0] addr;
        int          bc;
    } burst_t;

    burst_t      mq[$];
    burst_t      log_q[$];
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_beats = 0;
    int unsigned m_err = 0;
    int unsigned m_first = 32'hFFFF_FFFF;
    int unsigned m_cyc = 0;
    int unsigned m_idx = 0;
    bit          chk_en = 0;
    int          stall_cnt = 0;

    logic        p_rst = 0, p_stb = 0, p_read = 0, p_wait = 0, p_valid = 0, p_corrupt = 0;
    logic [31:0] p_base = 0, p_size = 0;
    logic [27:0] p_addr = 0;
    logic [7:0]  p_bc = 0;

    initial begin
        bit          pre_busy;
        bit          pre_done;
        bit          exp_read;
        int unsigned rem;
        int unsigned off;
        burst_t      b;
        forever begin
            @(negedge clk);
            // Account for the clock edge that just passed, using what was presented before it.
            pre_busy = m_busy;
            pre_done = m_done;
            if (p_rst === 1'b1) begin
                m_busy = 0; m_done = 0; m_beats = 0; mq.delete();
                m_err = 0; m_first = 32'hFFFF_FFFF; m_cyc = 0; m_idx = 0;
                chk_en = 1;
            end else begin
                if (pre_busy) m_cyc++;
                m_done = 0;
                if (pre_done) begin
                    m_busy = 0;
                end else if (!pre_busy) begin
                    if (p_stb === 1'b1) begin
                        m_busy = 1; m_cyc = 0; m_err = 0; m_first = 32'hFFFF_FFFF;
                        m_idx = 0; m_beats = 0; mq.delete();
                        rem = p_size; off = 0;
                        while (rem > 0) begin
                            b.addr = 28'(p_base + off);
                            b.bc   = (rem > 64) ? 64 : int'(rem);
                            mq.push_back(b);
                            rem -= b.bc;
                            off += b.bc;
                        end
                        if (p_size == 0) m_done = 1;
                    end
                end else if (m_beats == 0) begin
                    if (p_read === 1'b1 && p_wait === 1'b0 && mq.size() > 0) begin
                        m_beats = mq[0].bc;
                        void'(mq.pop_front());
                    end
                end else if (p_valid === 1'b1) begin
                    if (p_corrupt) begin
                        if (m_err != 32'hFFFF_FFFF) m_err++;
                        if (m_first == 32'hFFFF_FFFF) m_first = m_idx;
                    end
                    m_idx++;
                    m_beats--;
                    if (m_beats == 0 && mq.size() == 0) m_done = 1;
                end
            end
            if (p_read === 1'b1 && p_wait === 1'b0 && p_rst !== 1'b1) begin
                b.addr = p_addr;
                b.bc   = int'(p_bc);
                log_q.push_back(b);
            end

            if (chk_en) begin
                exp_read = m_busy && !m_done && m_beats == 0 && mq.size() > 0;
                check("busy", 64'(busy), 64'(m_busy));
                check("done", 64'(done), 64'(m_done));
                check("err_cnt", 64'(err_cnt), 64'(m_err));
                check("first_err", 64'(first_err), 64'(m_first));
                check("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
                check("read", 64'(avm_if.avm_read_o), 64'(exp_read));
                if (exp_read) begin
                    check("address", 64'(avm_if.avm_address_o), 64'(mq[0].addr));
                    check("burstcount", 64'(avm_if.avm_burstcount_o), 64'(mq[0].bc));
                end
                if (p_read === 1'b1 && p_wait === 1'b1 && p_rst !== 1'b1) begin
                    stall_cnt++;
                    check("stall_read", 64'(avm_if.avm_read_o), 64'd1);
                    check("stall_addr", 64'(avm_if.avm_address_o), 64'(p_addr));
                    check("stall_bc", 64'(avm_if.avm_burstcount_o), 64'(p_bc));
                end
            end

            p_rst     = rst;
            p_stb     = run_stb;
            p_base    = base_addr;
            p_size    = size;
            p_read    = avm_if.avm_read_o;
            p_wait    = avm_if.avm_waitrequest_i;
            p_addr    = avm_if.avm_address_o;
            p_bc      = avm_if.avm_burstcount_o;
            p_valid   = avm_if.avm_readdatavalid_i;
            p_corrupt = cur_corrupt;
        end
    end

    // ---------------- Stimulus ----------------
    task automatic wait_slave_idle();
        int i;
        for (i = 0; i < 3000 && s_pend != 0; i++) @(posedge clk);
        if (s_pend != 0) flag_timeout("slave_idle");
        repeat (3) @(posedge clk);
    endtask

    task automatic run(input logic [31:0] b, input logic [31:0] s, input int hold,
                       input bit second_stb, output int lat);
        bit got;
        wait_slave_idle();
        s_n = 0;
        hold_left = hold;
        log_q.delete();
        stall_cnt = 0;
        #1;
        base_addr = b;
        size      = s;
        run_stb   = 1'b1;
        @(posedge clk); #1;
        run_stb   = 1'b0;
        lat = 0;
        got = 0;
        if (second_stb) begin
            @(posedge clk); #1;
            base_addr = 32'h0000_5000;
            size      = 32'd3;
            run_stb   = 1'b1;
            @(posedge clk); #1;
            run_stb   = 1'b0;
            lat = 2;
        end
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) got = 1;
        end
        if (!got) flag_timeout("done_wait");
        @(negedge clk);
    endtask

    task automatic clear_corrupt();
        for (int i = 0; i < 512; i++) corrupt_map[i] = 0;
    endtask

    initial begin
        int lat;
        int sz;
        rst = 1'b1;
        run_stb = 1'b0;
        base_addr = '0;
        size = '0;
        clear_corrupt();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_first_err", 64'(first_err), 64'hFFFF_FFFF);
        check("rst_burstcount", 64'(avm_if.avm_burstcount_o), 64'd0);

        // Single short burst.
        run(32'h100, 32'd4, 0, 0, lat);
        check("r1_nbursts", 64'(log_q.size()), 64'd1);
        if (log_q.size() == 1) begin
            check("r1_addr", 64'(log_q[0].addr), 64'h100);
            check("r1_bc", 64'(log_q[0].bc), 64'd4);
        end
        check("r1_err", 64'(err_cnt), 64'd0);
        check("r1_first", 64'(first_err), 64'hFFFF_FFFF);
        check("r1_done_low", 64'(done), 64'd0);

        // Split into 64, 64, 2.
        run(32'h200, 32'd130, 0, 0, lat);
        check("r2_nbursts", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            check("r2_addr0", 64'(log_q[0].addr), 64'h200);
            check("r2_addr1", 64'(log_q[1].addr), 64'h240);
            check("r2_addr2", 64'(log_q[2].addr), 64'h280);
            check("r2_bc0", 64'(log_q[0].bc), 64'd64);
            check("r2_bc2", 64'(log_q[2].bc), 64'd2);
        end

        // Words 3 and 7 corrupted.
        clear_corrupt();
        corrupt_map[3] = 1;
        corrupt_map[7] = 1;
        run(32'h0, 32'd10, 0, 0, lat);
        check("r3_err", 64'(err_cnt), 64'd2);
        check("r3_first", 64'(first_err), 64'd3);
        clear_corrupt();

        // Zero size: done in the cycle after the strobe cycle, no read issued.
        run(32'h40, 32'd0, 0, 0, lat);
        check("r4_done_lat", 64'(lat), 64'd1);
        check("r4_cycle_cnt", 64'(cycle_cnt), 64'd1);
        check("r4_nbursts", 64'(log_q.size()), 64'd0);
        check("r4_first", 64'(first_err), 64'hFFFF_FFFF);

        // Five stalled request cycles plus an ignored second strobe.
        run(32'h1000, 32'd20, 5, 1, lat);
        check("r5_nbursts", 64'(log_q.size()), 64'd1);
        if (log_q.size() == 1) check("r5_addr", 64'(log_q[0].addr), 64'h1000);
        check("r5_stalls_ge5", 64'(stall_cnt >= 5), 64'd1);

        // Address wraps at 2^28.
        run(32'h0FFF_FFF0, 32'd100, 0, 0, lat);
        check("r6_nbursts", 64'(log_q.size()), 64'd2);
        if (log_q.size() == 2) begin
            check("r6_addr0", 64'(log_q[0].addr), 64'hFFF_FFF0);
            check("r6_addr1", 64'(log_q[1].addr), 64'h000_0030);
            check("r6_bc1", 64'(log_q[1].bc), 64'd36);
        end

        // Reset mid-receive with every word corrupt; stray beats must not count.
        wait_slave_idle();
        for (int i = 0; i < 512; i++) corrupt_map[i] = 1;
        s_n = 0;
        hold_left = 0;
        #1;
        base_addr = 32'h300;
        size = 32'd64;
        run_stb = 1'b1;
        @(posedge clk); #1 run_stb = 1'b0;
        for (int i = 0; i < 1000 && m_idx < 3; i++) @(posedge clk);
        if (m_idx < 3) flag_timeout("r7_recv");
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("r7_busy", 64'(busy), 64'd0);
        check("r7_read", 64'(avm_if.avm_read_o), 64'd0);
        check("r7_bc", 64'(avm_if.avm_burstcount_o), 64'd0);
        check("r7_cycle", 64'(cycle_cnt), 64'd0);
        wait_slave_idle();
        check("r7_err_after_strays", 64'(err_cnt), 64'd0);
        check("r7_first_after_strays", 64'(first_err), 64'hFFFF_FFFF);
        clear_corrupt();

        // Random runs.
        for (int r = 0; r < 8; r++) begin
            clear_corrupt();
            sz = $urandom_range(0, 200);
            for (int i = 0; i < sz; i++) corrupt_map[i] = ($urandom_range(0, 9) == 0);
            run($urandom, 32'(sz), $urandom_range(0, 3), bit'($urandom_range(0, 1)), lat);
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
